// File: rtl/mcu_spi_byte_frontend.sv
// mcu_spi_byte_frontend: clocked SPI mode-0 slave front end with rx valid/ready and tx holding register
// Define MCU_SPI_MSB_FIRST_EN for MSB-first shifting; the default is LSB-first in both directions.
module mcu_spi_byte_frontend #(
  parameter int          SYNC_STAGES = 2,
  parameter int          IDX_W       = 4,
  parameter logic [7:0]  TX_IDLE     = 8'h00
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             spi_nss,
  input  logic             spi_sck,
  input  logic             spi_mosi,
  output logic             spi_miso,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [IDX_W-1:0] rx_index,
  output logic             rx_overrun,
  input  logic [7:0]       tx_data,
  input  logic             tx_load,
  output logic             tx_pending,
  output logic             frame_start,
  output logic             frame_end,
  output logic             frame_active
);
  logic [SYNC_STAGES-1:0] nss_sync, sck_sync, mosi_sync;
  logic nss_d, sck_d, nss_s, sck_s, mosi_s;
  logic nss_fall, nss_rise, sck_rise, sck_fall, byte_cmpl, boundary, byte_done;
  logic [2:0] bit_cnt;
  logic [IDX_W-1:0] byte_cnt, done_idx;
  logic [7:0] rx_shift, rx_next, tx_shift, tx_hold, tx_byte, tx_rot;
  logic tx_first, tx_rot_bit;
  assign nss_s     = nss_sync[SYNC_STAGES-1];
  assign sck_s     = sck_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign nss_fall  = nss_d & ~nss_s;
  assign nss_rise  = ~nss_d & nss_s;
  assign sck_rise  = ~nss_s & sck_s & ~sck_d;
  assign sck_fall  = ~nss_s & ~sck_s & sck_d;
  assign byte_cmpl = sck_rise & (bit_cnt == 3'd7);
  assign boundary  = nss_fall | byte_cmpl;
  assign tx_byte   = tx_pending ? tx_hold : TX_IDLE;
`ifdef MCU_SPI_MSB_FIRST_EN
  assign rx_next    = {rx_shift[6:0], mosi_s};
  assign tx_first   = tx_byte[7];
  assign tx_rot     = {tx_shift[6:0], tx_shift[7]};
  assign tx_rot_bit = tx_shift[6];
`else
  assign rx_next    = {mosi_s, rx_shift[7:1]};
  assign tx_first   = tx_byte[0];
  assign tx_rot     = {tx_shift[0], tx_shift[7:1]};
  assign tx_rot_bit = tx_shift[1];
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nss_sync     <= '1;
      sck_sync     <= '0;
      mosi_sync    <= '0;
      nss_d        <= 1'b1;
      sck_d        <= 1'b0;
      bit_cnt      <= '0;
      byte_cnt     <= '0;
      done_idx     <= '0;
      byte_done    <= 1'b0;
      rx_shift     <= '0;
      tx_shift     <= '0;
      tx_hold      <= '0;
      tx_pending   <= 1'b0;
      spi_miso     <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_index     <= '0;
      rx_overrun   <= 1'b0;
      frame_start  <= 1'b0;
      frame_end    <= 1'b0;
      frame_active <= 1'b0;
    end else begin
      nss_sync     <= {nss_sync[SYNC_STAGES-2:0], spi_nss};
      sck_sync     <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      mosi_sync    <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      nss_d        <= nss_s;
      sck_d        <= sck_s;
      frame_start  <= nss_fall;
      frame_end    <= nss_rise;
      frame_active <= ~nss_s;
      byte_done    <= byte_cmpl;
      if (nss_fall) begin
        bit_cnt  <= '0;
        byte_cnt <= '0;
      end else if (nss_rise) begin
        bit_cnt <= '0;
      end else if (sck_rise) begin
        rx_shift <= rx_next;
        bit_cnt  <= bit_cnt + 3'd1;
        if (byte_cmpl) begin
          done_idx <= byte_cnt;
          byte_cnt <= (byte_cnt == '1) ? byte_cnt : byte_cnt + 1'b1;
        end
      end
      // accept-then-load: a consumer handshake in the same clk frees the slot
      if (byte_done && (!rx_valid || rx_ready)) begin
        rx_data  <= rx_shift;
        rx_index <= done_idx;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (nss_fall)
        rx_overrun <= 1'b0;
      else if (byte_done && rx_valid && !rx_ready)
        rx_overrun <= 1'b1;
      // no advance on the fall that follows a byte boundary: the next byte's first bit is already out
      if (boundary) begin
        tx_shift <= tx_byte;
        spi_miso <= tx_first;
      end else if (nss_rise) begin
        spi_miso <= 1'b0;
      end else if (sck_fall && bit_cnt != 3'd0) begin
        tx_shift <= tx_rot;
        spi_miso <= tx_rot_bit;
      end
      if (tx_load)
        tx_hold <= tx_data;
      tx_pending <= tx_load | (tx_pending & ~boundary);
    end
  end
endmodule
